// File: rtl/aes_dec_controller.sv
// Sequencer for the iterative AES-128 decryption datapath: key fetch,
// inverse round steps and InvMixColumns column walk on one state register.
module aes_dec_controller #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_aes_start,
    input  logic       i_key_ready,
    output logic       o_key_start,
    output logic       o_state_ld,
    output logic [2:0] o_op_sel,
    output logic [3:0] o_rkey_idx,
    output logic [1:0] o_mix_col,
    output logic       o_busy,
    output logic       o_aes_done
);

    localparam logic [3:0] LP_ROUNDS = 4'(NUM_ROUNDS);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_ARK  = 3'd2;
    localparam logic [2:0] OP_ISR  = 3'd3;
    localparam logic [2:0] OP_ISB  = 3'd4;
    localparam logic [2:0] OP_IMC  = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_KEY_WAIT,
        S_ARK_INIT,
        S_ISR,
        S_ISB,
        S_ARK,
        S_IMC,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_rc;
    logic [3:0] w_rc_next;
    logic [1:0] r_cc;
    logic [1:0] w_cc_next;
    logic       w_active;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_rc    <= 4'd0;
            r_cc    <= 2'd0;
        end else begin
            r_state <= w_next;
            r_rc    <= w_rc_next;
            r_cc    <= w_cc_next;
        end
    end

    assign w_active = (r_state != S_IDLE) && (r_state != S_DONE);

    always_comb begin
        w_next      = r_state;
        w_rc_next   = r_rc;
        w_cc_next   = r_cc;
        o_key_start = 1'b0;
        o_state_ld  = 1'b0;
        o_op_sel    = OP_NONE;
        o_rkey_idx  = 4'd0;
        o_mix_col   = 2'd0;
        o_busy      = w_active;
        o_aes_done  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (i_aes_start) w_next = S_LOAD;
            end
            S_LOAD: begin
                o_op_sel    = OP_LOAD;
                o_state_ld  = 1'b1;
                o_key_start = 1'b1;
                w_rc_next   = LP_ROUNDS;
                w_next      = S_KEY_WAIT;
            end
            S_KEY_WAIT: begin
                if (i_key_ready) w_next = S_ARK_INIT;
            end
            S_ARK_INIT: begin
                o_op_sel   = OP_ARK;
                o_rkey_idx = r_rc;
                o_state_ld = 1'b1;
                w_rc_next  = r_rc - 4'd1;
                w_next     = S_ISR;
            end
            S_ISR: begin
                o_op_sel   = OP_ISR;
                o_state_ld = 1'b1;
                w_next     = S_ISB;
            end
            S_ISB: begin
                o_op_sel   = OP_ISB;
                o_state_ld = 1'b1;
                w_next     = S_ARK;
            end
            S_ARK: begin
                o_op_sel   = OP_ARK;
                o_rkey_idx = r_rc;
                o_state_ld = 1'b1;
                if (r_rc == 4'd0) begin
                    w_next = S_DONE;
                end else begin
                    w_cc_next = 2'd0;
                    w_next    = S_IMC;
                end
            end
            S_IMC: begin
                o_op_sel   = OP_IMC;
                o_mix_col  = r_cc;
                o_state_ld = 1'b1;
                w_cc_next  = r_cc + 2'd1;
                if (r_cc == 2'd3) begin
                    w_rc_next = r_rc - 4'd1;
                    w_next    = S_ISR;
                end
            end
            S_DONE: begin
                o_aes_done = 1'b1;
                if (!i_aes_start) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // Software dropping start mid-run abandons it; counters are left
        // alone since LOAD reinitialises them on the next run.
        if (w_active && !i_aes_start) begin
            w_next    = S_IDLE;
            w_rc_next = r_rc;
            w_cc_next = r_cc;
        end
    end

endmodule

// File: tb/tb_aes_dec_controller.sv
// Bench for aes_dec_controller: schedule-list model checked every cycle on
// a 10-round and a 2-round instance, plus directed timing expectations.
module tb_aes_dec_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       st[2];
    logic       kr[2];
    logic       ks[2];
    logic       ld[2];
    logic       busy[2];
    logic       dn[2];
    logic [2:0] op[2];
    logic [3:0] rk[2];
    logic [1:0] mx[2];

    int checks = 0;
    int errors = 0;

    aes_dec_controller #(.NUM_ROUNDS(10)) u_dut10 (
        .i_clk(clk), .i_reset(rst), .i_aes_start(st[0]), .i_key_ready(kr[0]),
        .o_key_start(ks[0]), .o_state_ld(ld[0]), .o_op_sel(op[0]),
        .o_rkey_idx(rk[0]), .o_mix_col(mx[0]), .o_busy(busy[0]),
        .o_aes_done(dn[0])
    );

    aes_dec_controller #(.NUM_ROUNDS(2)) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_aes_start(st[1]), .i_key_ready(kr[1]),
        .o_key_start(ks[1]), .o_state_ld(ld[1]), .o_op_sel(op[1]),
        .o_rkey_idx(rk[1]), .o_mix_col(mx[1]), .o_busy(busy[1]),
        .o_aes_done(dn[1])
    );

    // Model: a run is a precomputed list of per-cycle operations.
    int nr[2] = '{10, 2};
    int mode[2];
    int pos[2];
    int len[2];
    int mop[2][128];
    int mrk[2][128];
    int mmx[2][128];
    bit armed = 1'b0;

    task automatic add(input int i, inout int p, input int o, input int k, input int m);
        mop[i][p] = o;
        mrk[i][p] = k;
        mmx[i][p] = m;
        p++;
    endtask

    task automatic build(input int i);
        int p;
        int n;
        p = 0;
        n = nr[i];
        add(i, p, 1, 0, 0);
        add(i, p, 0, 0, 0);
        add(i, p, 2, n, 0);
        for (int r = n - 1; r >= 1; r--) begin
            add(i, p, 3, 0, 0);
            add(i, p, 4, 0, 0);
            add(i, p, 2, r, 0);
            for (int c = 0; c < 4; c++) add(i, p, 5, 0, c);
        end
        add(i, p, 3, 0, 0);
        add(i, p, 4, 0, 0);
        add(i, p, 2, 0, 0);
        len[i] = p;
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mode[i] = 0;
            end else if (mode[i] == 0) begin
                if (st[i]) begin
                    mode[i] = 1;
                    pos[i] = 0;
                end
            end else if (mode[i] == 1) begin
                if (!st[i]) begin
                    mode[i] = 0;
                end else if (!(pos[i] == 1 && !kr[i])) begin
                    pos[i]++;
                    if (pos[i] == len[i]) mode[i] = 2;
                end
            end else begin
                if (!st[i]) mode[i] = 0;
            end
        end
    end

    function automatic logic [12:0] expv(input int i);
        int o;
        logic [12:0] v;
        v = '0;
        if (mode[i] == 1) begin
            o = mop[i][pos[i]];
            v = {o == 1, o != 0, 3'(o), 4'(mrk[i][pos[i]]),
                 2'(mmx[i][pos[i]]), 1'b1, 1'b0};
        end else if (mode[i] == 2) begin
            v = 13'd1;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                logic [12:0] a;
                logic [12:0] e;
                a = {ks[i], ld[i], op[i], rk[i], mx[i], busy[i], dn[i]};
                e = expv(i);
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL model_cycle inst%0d t=%0t got %b required %b",
                             i, $time, a, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, exp);
        end
    endtask

    int r_done, r_ks_k, r_ks_n, r_ld_n, r_ld_wait, r_kw_n;
    int rkseq[$];
    int mxseq[$];

    task automatic run(input int i, input int stall);
        int k;
        k = 0;
        r_done = -1; r_ks_k = -1; r_ks_n = 0;
        r_ld_n = 0; r_ld_wait = 0; r_kw_n = 0;
        rkseq.delete();
        mxseq.delete();
        kr[i] = (stall == 0);
        st[i] = 1'b1;
        while (k < 300 && r_done < 0) begin
            @(negedge clk);
            k++;
            if (ks[i]) begin
                r_ks_n++;
                r_ks_k = k - 1;
            end
            if (ld[i]) begin
                r_ld_n++;
                if (k >= 2 && k <= stall + 2) r_ld_wait++;
            end
            if (busy[i] && op[i] == 3'd0) r_kw_n++;
            if (op[i] == 3'd2) rkseq.push_back(int'(rk[i]));
            if (op[i] == 3'd5) mxseq.push_back(int'(mx[i]));
            if (dn[i]) r_done = k - 1;
            kr[i] = (stall == 0) || (k >= stall + 2);
        end
    endtask

    int t_op[13] = '{1, 0, 2, 3, 4, 2, 5, 5, 5, 5, 3, 4, 2};
    int t_rk[13] = '{0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    int t_mx[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0};

    initial begin
        int bad;
        int k;
        build(0);
        build(1);
        rst = 1'b1;
        st[0] = 1'b0; st[1] = 1'b0;
        kr[0] = 1'b1; kr[1] = 1'b1;
        @(negedge clk);
        armed = 1'b1;
        chk("reset_outputs",
            int'({ks[0], ld[0], op[0], rk[0], mx[0], busy[0], dn[0]}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal 10-round run
        run(0, 0);
        chk("nom_done_edge", r_done, 69);
        chk("nom_key_start_n", r_ks_n, 1);
        chk("nom_key_start_edge", r_ks_k, 0);
        chk("nom_state_ld_n", r_ld_n, 68);
        chk("nom_rkey_n", rkseq.size(), 11);
        for (int j = 0; j < rkseq.size() && j < 11; j++)
            chk($sformatf("nom_rkey_%0d", j), rkseq[j], 10 - j);
        chk("nom_mix_n", mxseq.size(), 36);
        bad = 0;
        foreach (mxseq[j]) if (mxseq[j] != j % 4) bad++;
        chk("nom_mix_order", bad, 0);

        // Done hold, release, back-to-back restart
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!(dn[0] === 1'b1 && op[0] === 3'd0)) bad++;
        end
        chk("hold_done_cycles_bad", bad, 0);
        st[0] = 1'b0;
        @(negedge clk);
        chk("release_done", int'(dn[0]), 0);
        run(0, 0);
        chk("b2b_key_start_n", r_ks_n, 1);
        chk("b2b_done_edge", r_done, 69);

        // Key stall of 5 cycles
        st[0] = 1'b0;
        @(negedge clk);
        run(0, 5);
        chk("stall_done_edge", r_done, 74);
        chk("stall_kw_cycles", r_kw_n, 6);
        chk("stall_ld_in_wait", r_ld_wait, 0);
        chk("stall_state_ld_n", r_ld_n, 68);

        // Abort during round-4 InvSubBytes
        st[0] = 1'b0;
        @(negedge clk);
        st[0] = 1'b1;
        kr[0] = 1'b1;
        for (k = 1; k <= 40; k++) @(negedge clk);
        chk("abort_at_isb", int'(op[0]), 4);
        st[0] = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (ld[0] !== 1'b0 || dn[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
        end
        chk("abort_quiet_bad", bad, 0);
        run(0, 0);
        chk("abort_rerun_done_edge", r_done, 69);
        chk("abort_rerun_ld_n", r_ld_n, 68);

        // Reset mid-IMC at RC=5, CC=2 with start held high
        st[0] = 1'b0;
        @(negedge clk);
        st[0] = 1'b1;
        for (k = 1; k <= 37; k++) @(negedge clk);
        chk("rst_at_imc2", int'(op[0]) * 4 + int'(mx[0]), 22);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs",
            int'({ks[0], ld[0], op[0], rk[0], mx[0], busy[0], dn[0]}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_restart_load", int'(op[0]), 1);
        k = 0;
        while (k < 200 && dn[0] !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        chk("rst_restart_done", int'(dn[0]), 1);
        st[0] = 1'b0;
        @(negedge clk);

        // Two-round instance, literal schedule
        st[1] = 1'b1;
        kr[1] = 1'b1;
        for (k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k <= 13) begin
                chk($sformatf("r2_step_%0d", k),
                    int'(op[1]) * 100 + int'(rk[1]) * 10 + int'(mx[1]),
                    t_op[k-1] * 100 + t_rk[k-1] * 10 + t_mx[k-1]);
                if (k == 13) chk("r2_not_done_e12", int'(dn[1]), 0);
            end else begin
                chk("r2_done_e13", int'(dn[1]), 1);
            end
        end
        st[1] = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_dec_controller.md
# aes_dec_controller

Control FSM that sequences the iterative AES-128 decryption datapath behind the Avalon AES register interface. It starts on the software start bit and fetches the key schedule through a ready handshake. It then steps the shared state register through the inverse round operations, one operation per cycle and one InvMixColumns column per cycle, and holds done until software drops start.

## Interface
- NUM_ROUNDS, default 10, AES round count; legal range 2..15; RKEY_IDX width is fixed at 4.
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- AES_START  in  1  level start from software start register bit 0.
- KEY_READY  in  1  key-expansion unit has all round keys valid.
- KEY_START  out  1  one-cycle pulse that launches key expansion.
- STATE_LD  out  1  datapath state register loads the selected operation result this cycle.
- OP_SEL  out  3  operation select: 0 none, 1 LOAD_MSG, 2 AddRoundKey, 3 InvShiftRows, 4 InvSubBytes, 5 InvMixColumns.
- RKEY_IDX  out  4  round-key index used by AddRoundKey.
- MIX_COL  out  2  column processed by InvMixColumns (0..3).
- BUSY  out  1  high in every state except IDLE and DONE.
- AES_DONE  out  1  decrypted message in state register is valid.

## Operation
- All outputs are Moore, decoded from the registered state. Registers: state, round counter RC (4 b), column counter CC (2 b).
- IDLE: all outputs 0. If AES_START=1, go to LOAD.
- LOAD: OP_SEL=1, STATE_LD=1, KEY_START=1. Set RC=NUM_ROUNDS, go to KEY_WAIT.
- KEY_WAIT: OP_SEL=0. Stay while KEY_READY=0. When KEY_READY=1, go to ARK_INIT.
- ARK_INIT: OP_SEL=2, RKEY_IDX=RC (=NUM_ROUNDS), STATE_LD=1. Decrement RC, go to ISR.
- ISR: OP_SEL=3, STATE_LD=1. Go to ISB.
- ISB: OP_SEL=4, STATE_LD=1. Go to ARK.
- ARK: OP_SEL=2, RKEY_IDX=RC, STATE_LD=1.
  - If RC=0, go to DONE.
  - Otherwise clear CC and go to IMC.
- IMC: OP_SEL=5, MIX_COL=CC, STATE_LD=1. Increment CC.
  - When CC=3, decrement RC and go to ISR.
  - CC wraps 3→0.
- DONE: AES_DONE=1, STATE_LD=0. Stay while AES_START=1. Go to IDLE when AES_START=0.
- Abort: AES_START=0 sampled in any state other than IDLE or DONE returns the FSM to IDLE at the next edge. No further STATE_LD is issued.
- A KEY_READY that stays high from a previous run is accepted immediately. KEY_READY is ignored outside KEY_WAIT.
- RC arithmetic is unsigned 4-bit and never underflows, because ARK exits at RC=0.
- RKEY_IDX and MIX_COL are 0 in states that do not use them.

## Timing
- RESET has priority over everything. Next state is IDLE, RC=0, CC=0, and every output is 0 on the cycle after the reset edge.
- Let E0 be the edge that samples AES_START=1 in IDLE, with KEY_READY=1 at E1. The state sequence is:
  - after E0: LOAD;
  - after E1: KEY_WAIT;
  - after E2: ARK_INIT;
  - E3..E(7·NUM_ROUNDS−5): NUM_ROUNDS−1 middle rounds of 7 cycles (ISR, ISB, ARK, IMC×4);
  - next 3 edges: final ISR, ISB, ARK(0);
  - DONE after edge E(7·NUM_ROUNDS−1), i.e. E69 for 10 rounds.
- Each extra KEY_READY=0 cycle in KEY_WAIT adds exactly one cycle of latency.
- KEY_START is high for exactly one cycle per run.
- STATE_LD count per run is 1 + 1 + 7·(NUM_ROUNDS−1) + 3 = 68 for 10 rounds.
- AES_DONE rises one cycle after the final ARK. It falls one cycle after AES_START is sampled low.
- A new run needs AES_START to go low at least one cycle, because DONE→IDLE→LOAD.

## Test plan
- Reset: assert RESET mid-IMC (RC=5, CC=2) -> next cycle state IDLE, all outputs 0. AES_START held high then starts a fresh run with LOAD.
- Nominal: KEY_READY tied 1, pulse AES_START high from E0 -> the following all hold:
  - KEY_START exactly at cycle 1;
  - AES_DONE first high after E69;
  - 68 STATE_LD cycles;
  - RKEY_IDX sequence on OP_SEL=2 is 10,9,…,0;
  - MIX_COL sequence is 0,1,2,3 repeated 9 times.
- Key stall: KEY_READY low for 5 cycles after LOAD -> KEY_WAIT held 6 cycles, AES_DONE after E74, no STATE_LD during the wait.
- Abort: drop AES_START during round 4 ISB -> IDLE next edge, STATE_LD and AES_DONE stay 0. Reasserting AES_START gives a full 70-cycle run.
- Done hold: keep AES_START high 20 cycles after AES_DONE -> AES_DONE stays 1 and OP_SEL=0. Drop AES_START -> AES_DONE=0 the next cycle. Back-to-back restart gives KEY_START once.
- Parameter: NUM_ROUNDS=2 -> sequence LOAD, KEY_WAIT, ARK(2), ISR, ISB, ARK(1), IMC0..3, ISR, ISB, ARK(0), DONE after E13.
